// File: rtl/pipeline_mem_stage.sv
// MEM stage: data RAM / MMIO access, write-back select and MEM/WB register.
// Hosts the timer (TH/TL/TCON), LED register, free-running SysTick and timer IRQ.
module pipeline_mem_stage #(
  parameter int unsigned RAM_AW    = 8,
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [68:0] EXMEM_data,
  input  logic [4:0]  EXMEM_control,
  output logic [36:0] MEMWB_data,
  output logic        MEMWB_control,
  output logic        MEM_fwd_en,
  output logic [4:0]  MEM_fwd_addr,
  output logic [31:0] MEM_fwd_data,
  output logic [7:0]  led,
  output logic        irq
);

  logic [4:0]  addr_c;
  logic [31:0] store_data;
  logic [31:0] alu_out;
  logic        reg_write;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_to_reg;

  assign addr_c     = EXMEM_data[68:64];
  assign store_data = EXMEM_data[63:32];
  assign alu_out    = EXMEM_data[31:0];
  assign reg_write  = EXMEM_control[4];
  assign mem_write  = EXMEM_control[3];
  assign mem_read   = EXMEM_control[2];
  assign mem_to_reg = EXMEM_control[1:0];

  assign MEM_fwd_en   = reg_write && (addr_c != 5'd0);
  assign MEM_fwd_addr = addr_c;
  assign MEM_fwd_data = alu_out;

  logic              mmio_hit;
  logic [4:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;

  assign mmio_hit = (alu_out[31:28] == MMIO_BASE[31:28]);
  assign mmio_off = alu_out[4:0];
  assign ram_idx  = alu_out[RAM_AW+1:2];

  logic [31:0] ram [2**RAM_AW];
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  // RAM has no reset; sampling reset here drops a write coinciding with reset.
  always_ff @(posedge clk) begin
    if (reset && mem_write && !mmio_hit) begin
      ram[ram_idx] <= store_data;
    end
  end

  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (mem_read) begin
      if (mmio_hit) begin
        case (mmio_off)
          5'h00:   rd_data = th;
          5'h04:   rd_data = tl;
          5'h08:   rd_data = {29'd0, tcon};
          5'h0C:   rd_data = {24'd0, led};
          5'h14:   rd_data = systick;
          default: rd_data = '0;
        endcase
      end else begin
        rd_data = ram[ram_idx];
      end
    end
  end

  logic [31:0] wb_data;
  assign wb_data = (mem_to_reg == 2'b01) ? rd_data : alu_out;

  // CPU writes are placed after the timer update so they take precedence
  // for the register they touch; the other register keeps the timer result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      systick <= '0;
      irq     <= 1'b0;
    end else begin
      systick <= systick + 32'd1;
      irq     <= tcon[1] & tcon[2];
      if (tcon[0]) begin
        if (tl == '1) begin
          tl <= th;
          if (tcon[1]) tcon[2] <= 1'b1;
        end else begin
          tl <= tl + 32'd1;
        end
      end
      if (mem_write && mmio_hit) begin
        case (mmio_off)
          5'h00:   th   <= store_data;
          5'h04:   tl   <= store_data;
          5'h08:   tcon <= store_data[2:0];
          5'h0C:   led  <= store_data[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEMWB_data    <= '0;
      MEMWB_control <= 1'b0;
    end else begin
      MEMWB_data    <= {addr_c, wb_data};
      MEMWB_control <= reg_write;
    end
  end

endmodule
